sdram_bridge_arbiter: RTL and testbench

- Shares the single SDRAM bridge external interface (26-bit address, 16-bit data, acknowledge handshake) between two masters: m0 = MP3 decoder stream fetch, m1 = SD-card loader / CPU-side writer.
- Round-robin arbitration, one transaction in flight.
- Registered bridge-side outputs and a timeout watchdog so a lost acknowledge cannot hang playback.
- Sits between the masters and the SDRAM system's bridge_0 port, in the clk_clk domain.

---
 rtl/sdram_bridge_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sdram_bridge_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_bridge_arbiter.sv
// rtl/sdram_bridge_arbiter.sv - round-robin two-master arbiter for the SDRAM bridge port
module sdram_bridge_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 16,
  parameter int BE_W    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byte_enable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_write_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_read_data,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byte_enable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_write_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_read_data,
  output logic [ADDR_W-1:0] br_address,
  output logic [BE_W-1:0]   br_byte_enable,
  output logic              br_read,
  output logic              br_write,
  output logic [DATA_W-1:0] br_write_data,
  input  logic              br_acknowledge,
  input  logic [DATA_W-1:0] br_read_data,
  output logic              timeout_pulse,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

  // Exit is taken on the edge after the watchdog shows TIMEOUT-1, giving TIMEOUT access cycles.
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

  state_t              r_state, w_state_nxt;
  logic                r_last_grant, w_last_grant_nxt;
  logic                r_gnt, w_gnt_nxt;
  logic [15:0]         r_wdog, w_wdog_nxt;
  logic [ADDR_W-1:0]   r_br_address, w_br_address_nxt;
  logic [BE_W-1:0]     r_br_be, w_br_be_nxt;
  logic [DATA_W-1:0]   r_br_wdata, w_br_wdata_nxt;
  logic                r_br_read, w_br_read_nxt;
  logic                r_br_write, w_br_write_nxt;
  logic                r_m0_ack, w_m0_ack_nxt;
  logic                r_m1_ack, w_m1_ack_nxt;
  logic [DATA_W-1:0]   r_m0_rdata, w_m0_rdata_nxt;
  logic [DATA_W-1:0]   r_m1_rdata, w_m1_rdata_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic                r_busy, w_busy_nxt;
  logic                w_req0, w_req1, w_pick;
  logic [DATA_W-1:0]   w_done_data;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;
  // On a tie the master that did not win last time gets the bridge.
  assign w_pick = (w_req0 && w_req1) ? ~r_last_grant : w_req1;

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_gnt_nxt        = r_gnt;
    w_wdog_nxt       = r_wdog;
    w_br_address_nxt = r_br_address;
    w_br_be_nxt      = r_br_be;
    w_br_wdata_nxt   = r_br_wdata;
    w_br_read_nxt    = r_br_read;
    w_br_write_nxt   = r_br_write;
    w_m0_ack_nxt     = 1'b0;
    w_m1_ack_nxt     = 1'b0;
    w_m0_rdata_nxt   = r_m0_rdata;
    w_m1_rdata_nxt   = r_m1_rdata;
    w_timeout_nxt    = 1'b0;
    w_done_data      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req0 || w_req1) begin
          w_gnt_nxt        = w_pick;
          w_last_grant_nxt = w_pick;
          w_wdog_nxt       = '0;
          w_br_address_nxt = w_pick ? m1_address     : m0_address;
          w_br_be_nxt      = w_pick ? m1_byte_enable : m0_byte_enable;
          w_br_wdata_nxt   = w_pick ? m1_write_data  : m0_write_data;
          // Write takes priority when a master raises both strobes.
          w_br_write_nxt   = w_pick ? m1_write : m0_write;
          w_br_read_nxt    = w_pick ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
          w_state_nxt      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_wdog_nxt = (r_wdog == 16'hFFFF) ? r_wdog : r_wdog + 16'd1;
        if (br_acknowledge || (r_wdog >= WDOG_LIMIT)) begin
          // A late acknowledge on the final watchdog cycle still counts as success.
          if (br_acknowledge && !r_br_write) begin
            w_done_data = br_read_data;
          end
          w_timeout_nxt  = ~br_acknowledge;
          w_br_read_nxt  = 1'b0;
          w_br_write_nxt = 1'b0;
          if (r_gnt) begin
            w_m1_ack_nxt   = 1'b1;
            w_m1_rdata_nxt = w_done_data;
          end else begin
            w_m0_ack_nxt   = 1'b1;
            w_m0_rdata_nxt = w_done_data;
          end
          w_state_nxt = S_RECOVER;
        end
      end
      S_RECOVER: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers; reset clears everything and favours m0 on the first tie.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_wdog       <= '0;
      r_br_address <= '0;
      r_br_be      <= '0;
      r_br_wdata   <= '0;
      r_br_read    <= 1'b0;
      r_br_write   <= 1'b0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gnt        <= w_gnt_nxt;
      r_wdog       <= w_wdog_nxt;
      r_br_address <= w_br_address_nxt;
      r_br_be      <= w_br_be_nxt;
      r_br_wdata   <= w_br_wdata_nxt;
      r_br_read    <= w_br_read_nxt;
      r_br_write   <= w_br_write_nxt;
      r_m0_ack     <= w_m0_ack_nxt;
      r_m1_ack     <= w_m1_ack_nxt;
      r_m0_rdata   <= w_m0_rdata_nxt;
      r_m1_rdata   <= w_m1_rdata_nxt;
      r_timeout    <= w_timeout_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign br_address     = r_br_address;
  assign br_byte_enable = r_br_be;
  assign br_write_data  = r_br_wdata;
  assign br_read        = r_br_read;
  assign br_write       = r_br_write;
  assign m0_ack         = r_m0_ack;
  assign m1_ack         = r_m1_ack;
  assign m0_read_data   = r_m0_rdata;
  assign m1_read_data   = r_m1_rdata;
  assign timeout_pulse  = r_timeout;
  assign busy           = r_busy;

endmodule

// File: tb/tb_sdram_bridge_arbiter.sv
// tb/tb_sdram_bridge_arbiter.sv - directed table-driven bench for sdram_bridge_arbiter
module tb_sdram_bridge_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [25:0] m0_address, m1_address, br_address;
  logic [1:0]  m0_byte_enable, m1_byte_enable, br_byte_enable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_write_data, m1_write_data, br_write_data;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_read_data, m1_read_data, br_read_data;
  logic        br_read, br_write, br_acknowledge;
  logic        timeout_pulse, busy;

  always #5 clk_clk = ~clk_clk;

  sdram_bridge_arbiter #(.ADDR_W(26), .DATA_W(16), .BE_W(2), .TIMEOUT(8)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m0_address), .m0_byte_enable(m0_byte_enable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_write_data(m0_write_data), .m0_ack(m0_ack),
    .m0_read_data(m0_read_data),
    .m1_address(m1_address), .m1_byte_enable(m1_byte_enable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_write_data(m1_write_data), .m1_ack(m1_ack),
    .m1_read_data(m1_read_data),
    .br_address(br_address), .br_byte_enable(br_byte_enable), .br_read(br_read),
    .br_write(br_write), .br_write_data(br_write_data), .br_acknowledge(br_acknowledge),
    .br_read_data(br_read_data), .timeout_pulse(timeout_pulse), .busy(busy)
  );

  typedef struct {
    logic m0r; logic m0w; logic [25:0] m0a;
    logic m1r; logic m1w; logic [25:0] m1a; logic [15:0] m1wd; logic [1:0] m1be;
    logic ack; logic [15:0] rdata;
    logic e_brr; logic e_brw; logic [25:0] e_bra; logic [15:0] e_brwd; logic [1:0] e_brbe;
    logic e_a0; logic e_a1; logic [15:0] e_rd0; logic [15:0] e_rd1; logic e_busy; logic e_to;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  initial begin
    int hi;
    // m0 write data / byte enables are fixed; m0 only reads in this bench.
    m0_write_data = 16'hC0DE; m0_byte_enable = 2'b11;
    m0_address = '0; m1_address = '0; m1_write_data = '0; m1_byte_enable = '0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    br_acknowledge = 0; br_read_data = '0;
    reset_reset_n = 0;

    // Section A: both masters held from reset, grants alternate 0,1,0,1 (row 9 raises m1 read+write).
    vecs[0]  = '{1,0,26'h10, 0,1,26'h20,16'h5A5A,2'b01, 0,16'h0000, 1,0,26'h10,16'hC0DE,2'b11, 0,0,16'h0000,16'h0000, 1,0};
    vecs[1]  = '{1,0,26'h10, 0,1,26'h20,16'h5A5A,2'b01, 1,16'h1111, 0,0,26'h10,16'hC0DE,2'b11, 1,0,16'h1111,16'h0000, 1,0};
    vecs[2]  = '{1,0,26'h10, 0,1,26'h20,16'h5A5A,2'b01, 0,16'h0000, 0,0,26'h10,16'hC0DE,2'b11, 0,0,16'h1111,16'h0000, 0,0};
    vecs[3]  = '{1,0,26'h10, 0,1,26'h20,16'h5A5A,2'b01, 0,16'h0000, 0,1,26'h20,16'h5A5A,2'b01, 0,0,16'h1111,16'h0000, 1,0};
    vecs[4]  = '{1,0,26'h10, 0,1,26'h20,16'h5A5A,2'b01, 1,16'h2222, 0,0,26'h20,16'h5A5A,2'b01, 0,1,16'h1111,16'h0000, 1,0};
    vecs[5]  = '{1,0,26'h10, 0,1,26'h20,16'h5A5A,2'b01, 0,16'h0000, 0,0,26'h20,16'h5A5A,2'b01, 0,0,16'h1111,16'h0000, 0,0};
    vecs[6]  = '{1,0,26'h10, 0,1,26'h20,16'h5A5A,2'b01, 0,16'h0000, 1,0,26'h10,16'hC0DE,2'b11, 0,0,16'h1111,16'h0000, 1,0};
    vecs[7]  = '{1,0,26'h10, 0,1,26'h20,16'h5A5A,2'b01, 1,16'h3333, 0,0,26'h10,16'hC0DE,2'b11, 1,0,16'h3333,16'h0000, 1,0};
    vecs[8]  = '{1,0,26'h10, 0,1,26'h20,16'h5A5A,2'b01, 0,16'h0000, 0,0,26'h10,16'hC0DE,2'b11, 0,0,16'h3333,16'h0000, 0,0};
    vecs[9]  = '{1,0,26'h10, 1,1,26'h20,16'h5A5A,2'b01, 0,16'h0000, 0,1,26'h20,16'h5A5A,2'b01, 0,0,16'h3333,16'h0000, 1,0};
    vecs[10] = '{1,0,26'h10, 1,1,26'h20,16'h5A5A,2'b01, 1,16'h4444, 0,0,26'h20,16'h5A5A,2'b01, 0,1,16'h3333,16'h0000, 1,0};
    vecs[11] = '{0,0,26'h10, 0,0,26'h20,16'h5A5A,2'b01, 0,16'h0000, 0,0,26'h20,16'h5A5A,2'b01, 0,0,16'h3333,16'h0000, 0,0};
    // Section B: m0 read 0x1234, ack in 4th access cycle with 0xBEEF; spurious ack; m1 read.
    vecs[12] = '{1,0,26'h1234, 0,0,26'h20,16'h5A5A,2'b01, 0,16'h0000, 1,0,26'h1234,16'hC0DE,2'b11, 0,0,16'h3333,16'h0000, 1,0};
    vecs[13] = '{1,0,26'h1234, 0,0,26'h20,16'h5A5A,2'b01, 0,16'h0000, 1,0,26'h1234,16'hC0DE,2'b11, 0,0,16'h3333,16'h0000, 1,0};
    vecs[14] = '{1,0,26'h1234, 0,0,26'h20,16'h5A5A,2'b01, 0,16'h0000, 1,0,26'h1234,16'hC0DE,2'b11, 0,0,16'h3333,16'h0000, 1,0};
    vecs[15] = '{1,0,26'h1234, 0,0,26'h20,16'h5A5A,2'b01, 0,16'h0000, 1,0,26'h1234,16'hC0DE,2'b11, 0,0,16'h3333,16'h0000, 1,0};
    vecs[16] = '{1,0,26'h1234, 0,0,26'h20,16'h5A5A,2'b01, 1,16'hBEEF, 0,0,26'h1234,16'hC0DE,2'b11, 1,0,16'hBEEF,16'h0000, 1,0};
    vecs[17] = '{0,0,26'h1234, 0,0,26'h20,16'h5A5A,2'b01, 0,16'h0000, 0,0,26'h1234,16'hC0DE,2'b11, 0,0,16'hBEEF,16'h0000, 0,0};
    vecs[18] = '{0,0,26'h1234, 0,0,26'h20,16'h5A5A,2'b01, 1,16'h1111, 0,0,26'h1234,16'hC0DE,2'b11, 0,0,16'hBEEF,16'h0000, 0,0};
    vecs[19] = '{0,0,26'h1234, 1,0,26'h30,16'h5A5A,2'b01, 0,16'h0000, 1,0,26'h30,16'h5A5A,2'b01, 0,0,16'hBEEF,16'h0000, 1,0};
    vecs[20] = '{0,0,26'h1234, 1,0,26'h30,16'h5A5A,2'b01, 1,16'h6543, 0,0,26'h30,16'h5A5A,2'b01, 0,1,16'hBEEF,16'h6543, 1,0};
    vecs[21] = '{0,0,26'h1234, 0,0,26'h30,16'h5A5A,2'b01, 0,16'h0000, 0,0,26'h30,16'h5A5A,2'b01, 0,0,16'hBEEF,16'h6543, 0,0};

    // Reset state while reset is held low.
    #12;
    chk("rst.br_read", br_read, 0);
    chk("rst.br_write", br_write, 0);
    chk("rst.br_address", br_address, 0);
    chk("rst.acks", {m0_ack, m1_ack}, 0);
    chk("rst.read_data", {m0_read_data, m1_read_data}, 0);
    chk("rst.busy_to", {busy, timeout_pulse}, 0);
    step();
    reset_reset_n = 1;

    for (int i = 0; i < NV; i++) begin
      m0_read = vecs[i].m0r; m0_write = vecs[i].m0w; m0_address = vecs[i].m0a;
      m1_read = vecs[i].m1r; m1_write = vecs[i].m1w; m1_address = vecs[i].m1a;
      m1_write_data = vecs[i].m1wd; m1_byte_enable = vecs[i].m1be;
      br_acknowledge = vecs[i].ack; br_read_data = vecs[i].rdata;
      step();
      chk($sformatf("v%0d.br_read", i), br_read, vecs[i].e_brr);
      chk($sformatf("v%0d.br_write", i), br_write, vecs[i].e_brw);
      chk($sformatf("v%0d.br_address", i), br_address, vecs[i].e_bra);
      chk($sformatf("v%0d.br_write_data", i), br_write_data, vecs[i].e_brwd);
      chk($sformatf("v%0d.br_byte_enable", i), br_byte_enable, vecs[i].e_brbe);
      chk($sformatf("v%0d.m0_ack", i), m0_ack, vecs[i].e_a0);
      chk($sformatf("v%0d.m1_ack", i), m1_ack, vecs[i].e_a1);
      chk($sformatf("v%0d.m0_read_data", i), m0_read_data, vecs[i].e_rd0);
      chk($sformatf("v%0d.m1_read_data", i), m1_read_data, vecs[i].e_rd1);
      chk($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d.timeout_pulse", i), timeout_pulse, vecs[i].e_to);
    end

    // Watchdog: bridge never acks, TIMEOUT=8 gives 8 access cycles then a timeout completion.
    m1_read = 0; m1_write = 0;
    br_acknowledge = 0;
    m0_read = 1; m0_address = 26'hABC;
    step();
    hi = 0;
    for (int g = 0; g < 20 && br_read; g++) begin
      hi++;
      step();
    end
    chk("to.read_cycles", hi, 8);
    chk("to.m0_ack", m0_ack, 1);
    chk("to.timeout_pulse", timeout_pulse, 1);
    chk("to.m0_read_data", m0_read_data, 16'h0000);
    chk("to.m1_read_data_hold", m1_read_data, 16'h6543);
    m0_read = 0;
    step();
    chk("to.pulse_clear", {timeout_pulse, m0_ack}, 0);

    // Next request after a timeout is served normally.
    m0_read = 1; m0_address = 26'h55;
    step();
    chk("post_to.br_read", br_read, 1);
    br_acknowledge = 1; br_read_data = 16'h7777;
    step();
    chk("post_to.m0_ack", m0_ack, 1);
    chk("post_to.m0_read_data", m0_read_data, 16'h7777);
    chk("post_to.timeout_pulse", timeout_pulse, 0);
    m0_read = 0; br_acknowledge = 0;
    step();
    step();

    // Acknowledge on the last watchdog cycle wins over the timeout.
    m0_read = 1; m0_address = 26'h66;
    step();
    repeat (7) step();
    chk("coin.br_read_still", br_read, 1);
    br_acknowledge = 1; br_read_data = 16'h9999;
    step();
    chk("coin.m0_ack", m0_ack, 1);
    chk("coin.m0_read_data", m0_read_data, 16'h9999);
    chk("coin.timeout_pulse", timeout_pulse, 0);
    chk("coin.br_read", br_read, 0);
    m0_read = 0; br_acknowledge = 0;
    step();
    step();

    // Reset mid-access clears outputs asynchronously; afterwards m0 wins the first tie.
    m0_read = 1; m0_address = 26'h77; m1_address = 26'h88;
    step();
    step();
    chk("mid.br_read_before", br_read, 1);
    m1_read = 1;
    reset_reset_n = 0;
    #1;
    chk("mid.br_read", br_read, 0);
    chk("mid.br_write", br_write, 0);
    chk("mid.busy", busy, 0);
    chk("mid.acks", {m0_ack, m1_ack}, 0);
    #3;
    reset_reset_n = 1;
    step();
    chk("mid.regrant_addr", br_address, 26'h77);
    chk("mid.regrant_read", br_read, 1);
    br_acknowledge = 1; br_read_data = 16'hA5A5;
    step();
    chk("mid.m0_ack", {m0_ack, m1_ack}, 2'b10);
    chk("mid.m0_read_data", m0_read_data, 16'hA5A5);
    m0_read = 0; m1_read = 0; br_acknowledge = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
